// File: rtl/resp_signature_compactor.sv
// Response signature compactor: folds each 199-bit response word to 32 bits,
// accumulates it in a MISR and compares against a golden signature at the end.
module resp_signature_compactor #(
  parameter int                DATA_W = 199,
  parameter int                SIG_W  = 32,
  parameter logic [SIG_W-1:0]  POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  SEED   = 32'hFFFFFFFF,
  parameter int                CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [SIG_W-1:0]  expected_sig,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  sample_count
);

  localparam int NCHUNK = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W  = NCHUNK * SIG_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Top chunk is zero-padded, so the XOR never sees undriven bits.
  function automatic logic [SIG_W-1:0] fold_f(input logic [DATA_W-1:0] d);
    logic [PAD_W-1:0] padded;
    logic [SIG_W-1:0] acc;
    padded              = '0;
    padded[DATA_W-1:0]  = d;
    acc                 = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      acc = acc ^ padded[i*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [SIG_W-1:0] f);
    logic [SIG_W-1:0] fb;
    fb = s[SIG_W-1] ? POLY : '0;
    return {s[SIG_W-2:0], 1'b0} ^ fb ^ f;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] num_lat;
  logic [SIG_W-1:0] exp_lat;
  logic [SIG_W-1:0] sig_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             done_q;
  logic             pass_q;

  logic [SIG_W-1:0] fold_p0;
  logic [SIG_W-1:0] sig_next_p0;
  logic [CNT_W-1:0] cnt_inc_p0;
  logic             vld_p0;

  // Stage p0: combinational fold and next-signature of the incoming word
  assign fold_p0     = fold_f(sample_data);
  assign sig_next_p0 = misr_step(sig_p1, fold_p0);
  assign cnt_inc_p0  = cnt_p1 + CNT_W'(1);
  assign vld_p0      = (state == S_RUN) && sample_valid;

  // Stage p1: registered signature, count and run control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      num_lat <= '0;
      exp_lat <= '0;
      sig_p1  <= SEED;
      cnt_p1  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            num_lat <= num_samples;
            exp_lat <= expected_sig;
            sig_p1  <= SEED;
            cnt_p1  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            state   <= (num_samples == '0) ? S_CHECK : S_RUN;
          end
        end
        S_RUN: begin
          if (vld_p0) begin
            sig_p1 <= sig_next_p0;
            cnt_p1 <= cnt_inc_p0;
            if (cnt_inc_p0 == num_lat) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          pass_q <= (sig_p1 == exp_lat);
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state == S_RUN) || (state == S_CHECK);
  assign done         = done_q;
  assign pass         = pass_q;
  assign signature    = sig_p1;
  assign sample_count = cnt_p1;

endmodule

// File: doc/resp_signature_compactor.md
Name: resp_signature_compactor

Overview:
- Downstream consumer of the synthesised `top` under identity test.
- Samples the 199-bit response bus `y` on each valid clock and compresses it into a 32-bit MISR signature.
- After a programmed number of samples, compares the signature against an expected golden value and reports done and pass.
- Lets the bench check a whole run with one 32-bit compare instead of strobing every vector.

Parameters:
- DATA_W, 199: width of the response bus (y is [198:0]).
- SIG_W, 32: signature width.
- POLY, 32'h04C11DB7: MISR feedback polynomial.
- SEED, 32'hFFFFFFFF: signature value loaded at start.
- CNT_W, 8: width of the sample counter and of num_samples.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  pulse to begin a run; honoured in IDLE and DONE only.
- num_samples  input  CNT_W  number of samples to compact; latched on start.
- expected_sig  input  SIG_W  golden signature; latched on start.
- sample_valid  input  1  sample_data is valid this cycle.
- sample_data  input  DATA_W  response word from top.y.
- busy  output  1  high while in RUN or CHECK.
- done  output  1  high in DONE.
- pass  output  1  compare result; meaningful only when done=1.
- signature  output  SIG_W  current MISR value.
- sample_count  output  CNT_W  samples accepted in the current run.

Behaviour:
- Clock: one clock (clk). Reset: asynchronous, active-high (rst).
- Reset values, applied immediately when rst asserts:
  - state=IDLE
  - busy=0, done=0, pass=0
  - signature=SEED, sample_count=0
  - latched num_samples and expected_sig = 0
- Fold: split sample_data into ceil(DATA_W/SIG_W) chunks of SIG_W bits, LSB chunk first. Zero-pad the top chunk (bits 198..192 map to chunk 6, bits 6..0). XOR all chunks to form fold[SIG_W-1:0].
- MISR step: sig_next = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ fold.
- States and transitions:
  - IDLE: on start, latch num_samples and expected_sig, set signature=SEED and sample_count=0. If num_samples==0, go to CHECK; otherwise go to RUN.
  - RUN: on each sample_valid, apply the MISR step and increment sample_count. The accepting edge on which sample_count reaches the latched num_samples moves the state to CHECK.
    - sample_valid=0 holds all state.
    - start is ignored in RUN.
  - CHECK: exactly one cycle. Samples are ignored. On the exit edge, pass <= (signature==latched expected_sig), done <= 1, state goes to DONE.
  - DONE: hold done, pass, signature and sample_count. Samples are ignored.
    - start behaves as in IDLE and clears done and pass on the same edge.
    - Without start, DONE is held indefinitely.
- Latency: the final sample is accepted at edge k; done and pass are visible after edge k+1.
- Boundaries:
  - num_samples=255 runs the full count with no wrap.
  - start and sample_valid on the same edge in IDLE/DONE: the sample is not compacted.
  - rst mid-RUN aborts the run with no partial done.
  - The fold is purely combinational on sample_data; X on unused padding is impossible because padding is constant 0.
- Arithmetic: sample_count is compared at full CNT_W width; all XORs are SIG_W wide; there is no truncation apart from the shift discard of the MSB.

Test Plan:
1. Reset, then start with num_samples=1, expected_sig=32'hFB3EE249, and one sample_data=0 -> signature=FB3EE249; done=1 and pass=1 two edges after the sample; busy=0.
2. Same run with sample_data=1 -> signature=FB3EE248, pass=0 (mismatch), done=1.
3. Fold check, num_samples=1:
   - sample_data with bits 32 and 0 set -> signature=FB3EE249 (chunks cancel).
   - sample_data with only bit 198 set -> signature=FB3EE209.
4. Start with num_samples=0, expected_sig=FFFFFFFF -> CHECK on the next edge, then done=1, pass=1, sample_count=0, signature=FFFFFFFF.
5. num_samples=3 with sample_valid gaps (valid, idle, idle, valid, valid) -> sample_count increments only on valid cycles; done rises one edge after the third valid. A start pulse issued mid-RUN is ignored (num_samples is not re-latched).
6. Assert rst after 2 of 4 samples -> outputs drop to their reset values immediately. A fresh start then rebuilds the signature from SEED and matches a clean 4-sample run.
